// File: rtl/systolic_result_drain_if.sv
// Row-stream bus from the result drain toward writeback / next-layer activations.
// One beat carries a full requantized row plus its row index and a last flag.
interface systolic_result_drain_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int OUT_W = 8
);
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [COLS-1:0][OUT_W-1:0] out_data;
  logic [RIDX_W-1:0]          out_row_idx;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  // The drain drives the beat; the downstream consumer drives ready.
  modport master (
    output out_data,
    output out_row_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_row_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Systolic result drain: captures the ROWS x COLS accumulator matrix on a
// result_valid pulse and streams it out row by row, requantized to OUT_W with
// round-half-up and saturation. A new matrix may be captured on the same cycle
// as the final beat's handshake so consecutive matrices drain without a gap.
module systolic_result_drain #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 8,
  parameter int SAT_CNT_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // Elements are two's-complement accumulators; signedness is applied per element.
  input  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] result_matrix,
  input  logic                                 result_valid,
  input  logic [4:0]                           cfg_shift,
  output logic                                 capture_ready,
  systolic_result_drain_if.master              out_bus,
  output logic                                 overrun_err,
  output logic [SAT_CNT_W-1:0]                 sat_count
);

  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLIP_W = $clog2(COLS + 1);
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);
  localparam logic [4:0] SHIFT_MAX = (ACC_W > 32) ? 5'd31 : 5'(ACC_W - 1);
  localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                               state_r, state_nxt_s;
  logic [RIDX_W-1:0]                    row_ptr_r, row_ptr_nxt_s;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] buf_r;
  logic [4:0]                           shift_r;

  logic                                 drain_s;
  logic                                 last_row_s;
  logic                                 handshake_s;
  logic                                 capture_s;
  logic [COLS-1:0][OUT_W-1:0]           row_data_s;
  logic [CLIP_W-1:0]                    clip_cnt_s;
  logic [OUT_W:0]                       q_s;
  logic [SAT_CNT_W:0]                   sat_sum_s;

  // Requantize one accumulator: round half up, arithmetic shift, saturate.
  // Result is {clipped, value}. The extra sign bit keeps acc + bias from overflowing.
  function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0] acc,
                                             input logic [4:0]       s);
    logic signed [ACC_W:0] ext_v;
    logic signed [ACC_W:0] bias_v;
    logic signed [ACC_W:0] sum_v;
    logic signed [ACC_W:0] shr_v;
    ext_v = {acc[ACC_W-1], acc};
    if (s != 5'd0) begin
      bias_v = {{ACC_W{1'b0}}, 1'b1} << (s - 5'd1);
    end else begin
      bias_v = '0;
    end
    sum_v = ext_v + bias_v;
    shr_v = sum_v >>> s;
    if (shr_v > SAT_HI) begin
      requant = {1'b1, SAT_HI[OUT_W-1:0]};
    end else if (shr_v < SAT_LO) begin
      requant = {1'b1, SAT_LO[OUT_W-1:0]};
    end else begin
      requant = {1'b0, shr_v[OUT_W-1:0]};
    end
  endfunction

  // Handshake qualifiers and capture acceptance.
  always_comb begin
    drain_s       = (state_r == DRAIN);
    last_row_s    = (row_ptr_r == LAST_ROW);
    handshake_s   = drain_s && out_bus.out_ready;
    capture_ready = !drain_s || (last_row_s && out_bus.out_ready);
    capture_s     = result_valid && capture_ready;
  end

  // Requantize the currently selected buffer row and count clipped elements.
  always_comb begin
    row_data_s = '0;
    clip_cnt_s = '0;
    q_s        = '0;
    for (int c = 0; c < COLS; c++) begin
      q_s           = requant(buf_r[row_ptr_r][c], shift_r);
      row_data_s[c] = q_s[OUT_W-1:0];
      clip_cnt_s    = clip_cnt_s + CLIP_W'(q_s[OUT_W]);
    end
  end

  // Next state and row pointer.
  always_comb begin
    state_nxt_s   = state_r;
    row_ptr_nxt_s = row_ptr_r;
    case (state_r)
      IDLE: begin
        if (result_valid) begin
          state_nxt_s   = DRAIN;
          row_ptr_nxt_s = '0;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      DRAIN: begin
        if (handshake_s) begin
          if (!last_row_s) begin
            row_ptr_nxt_s = row_ptr_r + RIDX_W'(1);
          end else if (result_valid) begin
            // Back-to-back: the final handshake doubles as the next capture.
            state_nxt_s   = DRAIN;
            row_ptr_nxt_s = '0;
          end else begin
            state_nxt_s   = IDLE;
            row_ptr_nxt_s = '0;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        row_ptr_nxt_s = '0;
      end
    endcase
  end

  // Output beat; data is forced to zero whenever no beat is offered.
  always_comb begin
    out_bus.out_valid   = drain_s;
    out_bus.out_row_idx = row_ptr_r;
    out_bus.out_last    = drain_s && last_row_s;
    if (drain_s) begin
      out_bus.out_data = row_data_s;
    end else begin
      out_bus.out_data = '0;
    end
  end

  // Saturating add of this beat's clip count.
  always_comb begin
    sat_sum_s = {1'b0, sat_count} + (SAT_CNT_W + 1)'(clip_cnt_s);
  end

  // FSM state and row pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      row_ptr_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      row_ptr_r <= row_ptr_nxt_s;
    end
  end

  // Matrix buffer and shift latch; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      buf_r <= result_matrix;
      if (cfg_shift > SHIFT_MAX) begin
        shift_r <= SHIFT_MAX;
      end else begin
        shift_r <= cfg_shift;
      end
    end
  end

  // Sticky overrun flag and saturating clip counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_err <= 1'b0;
      sat_count   <= '0;
    end else begin
      if (result_valid && !capture_ready) begin
        overrun_err <= 1'b1;
      end
      if (handshake_s) begin
        if (sat_sum_s[SAT_CNT_W]) begin
          sat_count <= '1;
        end else begin
          sat_count <= sat_sum_s[SAT_CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level model (a queue of expected beats).
module tb_systolic_result_drain;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ACC_W     = 32;
  localparam int OUT_W     = 8;
  localparam int SAT_CNT_W = 16;
  localparam longint SAT_MAX = (longint'(1) << SAT_CNT_W) - 1;

  logic                                 clk = 1'b0;
  logic                                 reset;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] result_matrix;
  logic                                 result_valid;
  logic [4:0]                           cfg_shift;
  logic                                 capture_ready;
  logic                                 overrun_err;
  logic [SAT_CNT_W-1:0]                 sat_count;

  systolic_result_drain_if #(.ROWS(ROWS), .COLS(COLS), .OUT_W(OUT_W)) bus ();

  systolic_result_drain #(
    .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SAT_CNT_W(SAT_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .result_matrix(result_matrix),
    .result_valid (result_valid),
    .cfg_shift    (cfg_shift),
    .capture_ready(capture_ready),
    .out_bus      (bus.master),
    .overrun_err  (overrun_err),
    .sat_count    (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                         idx;
    logic [COLS-1:0][OUT_W-1:0] data;
    bit                         last;
    int                         clips;
  } beat_t;

  beat_t  exp_q[$];
  bit     m_overrun;
  longint m_sat;
  bit     m_known;
  int     errors;
  int     checks;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference requantization in plain integer arithmetic.
  function automatic longint ref_requant(input longint acc, input int s, output bit clipped);
    longint v;
    longint lo;
    longint hi;
    lo = -(longint'(1) << (OUT_W - 1));
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    v  = acc;
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    clipped = (v > hi) || (v < lo);
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

  // A captured matrix becomes ROWS expected beats.
  task automatic push_matrix(input logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] m, input logic [4:0] sh);
    int s;
    s = (int'(sh) > ACC_W - 1) ? ACC_W - 1 : int'(sh);
    for (int r = 0; r < ROWS; r++) begin
      beat_t b;
      b.idx   = r;
      b.last  = (r == ROWS - 1);
      b.clips = 0;
      for (int c = 0; c < COLS; c++) begin
        bit     cl;
        longint v;
        v = ref_requant(longint'($signed(m[r][c])), s, cl);
        b.data[c] = v[OUT_W-1:0];
        b.clips   = b.clips + int'(cl);
      end
      exp_q.push_back(b);
    end
  endtask

  // Check outputs mid-cycle, advance the model across the next edge.
  task automatic step_cycle();
    bit accept;
    @(negedge clk);
    if (m_known) begin
      check_val("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      check_val("capture_ready", 64'(capture_ready),
                64'(exp_q.size() == 0 || (exp_q.size() == 1 && bus.out_ready)));
      check_val("overrun_err", 64'(overrun_err), 64'(m_overrun));
      check_val("sat_count", 64'(sat_count), 64'(m_sat));
      if (exp_q.size() > 0) begin
        check_val("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
        check_val("out_row_idx", 64'(bus.out_row_idx), 64'(exp_q[0].idx));
        check_val("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
      end else begin
        check_val("idle_out_data", 64'(bus.out_data), 64'(0));
        check_val("idle_out_last", 64'(bus.out_last), 64'(0));
      end
    end
    accept = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready);
    if (exp_q.size() > 0 && bus.out_ready) begin
      m_sat = m_sat + exp_q[0].clips;
      if (m_sat > SAT_MAX) m_sat = SAT_MAX;
      void'(exp_q.pop_front());
    end
    if (result_valid) begin
      if (accept) push_matrix(result_matrix, cfg_shift);
      else m_overrun = 1'b1;
    end
    if (reset) begin
      exp_q.delete();
      m_overrun = 1'b0;
      m_sat     = 0;
      m_known   = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_capture(input logic [4:0] sh);
    cfg_shift    = sh;
    result_valid = 1'b1;
    step_cycle();
    result_valid = 1'b0;
  endtask

  task automatic rand_matrix();
    int v;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        case ($urandom_range(0, 2))
          0: v = int'($urandom_range(0, 400)) - 200;
          1: v = int'($urandom());
          default: v = int'($urandom_range(0, 8)) - 4;
        endcase
        result_matrix[r][c] = v;
      end
    end
  endtask

  initial begin
    logic [COLS-1:0][OUT_W-1:0] e;
    errors        = 0;
    checks        = 0;
    m_known       = 1'b0;
    m_overrun     = 1'b0;
    m_sat         = 0;
    reset         = 1'b1;
    result_valid  = 1'b0;
    cfg_shift     = 5'd0;
    result_matrix = '0;
    bus.out_ready = 1'b1;
    step_cycle();
    step_cycle();
    reset = 1'b0;

    // Reset state
    check_val("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_val("rst_out_row_idx", 64'(bus.out_row_idx), 64'(0));
    check_val("rst_out_data", 64'(bus.out_data), 64'(0));
    check_val("rst_out_last", 64'(bus.out_last), 64'(0));
    check_val("rst_capture_ready", 64'(capture_ready), 64'(1));
    check_val("rst_overrun_err", 64'(overrun_err), 64'(0));
    check_val("rst_sat_count", 64'(sat_count), 64'(0));

    // Basic drain: element = 4r+c, shift 0
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        result_matrix[r][c] = ACC_W'(4 * r + c);
    pulse_capture(5'd0);
    for (int b = 0; b < ROWS; b++) begin
      for (int c = 0; c < COLS; c++) e[c] = OUT_W'(4 * b + c);
      check_val("basic_row_idx", 64'(bus.out_row_idx), 64'(b));
      check_val("basic_data", 64'(bus.out_data), 64'(e));
      check_val("basic_last", 64'(bus.out_last), 64'(b == ROWS - 1));
      check_val("basic_cap_ready", 64'(capture_ready), 64'(b == ROWS - 1));
      step_cycle();
    end
    check_val("basic_done_valid", 64'(bus.out_valid), 64'(0));
    step_cycle();

    // Rounding
    result_matrix       = '0;
    result_matrix[0][0] = 32'd5;
    result_matrix[0][1] = -32'sd5;
    pulse_capture(5'd1);
    check_val("round_s1_pos", 64'(bus.out_data[0]), 64'(8'd3));
    check_val("round_s1_neg", 64'(bus.out_data[1]), 64'(8'hFE));
    repeat (ROWS) step_cycle();
    result_matrix[0][0] = 32'd6;
    result_matrix[0][1] = -32'sd6;
    pulse_capture(5'd2);
    check_val("round_s2_pos", 64'(bus.out_data[0]), 64'(8'd2));
    check_val("round_s2_neg", 64'(bus.out_data[1]), 64'(8'hFF));
    repeat (ROWS) step_cycle();
    check_val("round_sat_zero", 64'(sat_count), 64'(0));

    // Saturation
    result_matrix       = '0;
    result_matrix[0][0] = 32'd1000;
    result_matrix[0][1] = -32'sd1000;
    result_matrix[0][2] = 32'd127;
    pulse_capture(5'd0);
    check_val("sat_pos", 64'(bus.out_data[0]), 64'(8'h7F));
    check_val("sat_neg", 64'(bus.out_data[1]), 64'(8'h80));
    check_val("sat_edge", 64'(bus.out_data[2]), 64'(8'h7F));
    repeat (ROWS) step_cycle();
    check_val("sat_count_2", 64'(sat_count), 64'(2));
    result_matrix       = '0;
    result_matrix[0][0] = 32'h7FFF_FFFF;
    pulse_capture(5'd31);
    check_val("sat_shift31", 64'(bus.out_data[0]), 64'(8'd1));
    repeat (ROWS) step_cycle();

    // Backpressure on row 1
    rand_matrix();
    result_matrix[1][0] = 32'd5000;
    pulse_capture(5'd0);
    step_cycle();
    bus.out_ready = 1'b0;
    repeat (3) begin
      check_val("bp_row_idx", 64'(bus.out_row_idx), 64'(1));
      check_val("bp_last", 64'(bus.out_last), 64'(0));
      step_cycle();
    end
    bus.out_ready = 1'b1;
    repeat (ROWS) step_cycle();

    // Overrun while row 2 is presented
    rand_matrix();
    pulse_capture(5'd3);
    step_cycle();
    step_cycle();
    check_val("ovr_row2", 64'(bus.out_row_idx), 64'(2));
    rand_matrix();
    pulse_capture(5'd0);
    check_val("ovr_err_set", 64'(overrun_err), 64'(1));
    repeat (3) step_cycle();

    // Back-to-back capture on the row-3 handshake
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    rand_matrix();
    pulse_capture(5'd2);
    repeat (ROWS - 1) step_cycle();
    check_val("b2b_row3", 64'(bus.out_row_idx), 64'(ROWS - 1));
    rand_matrix();
    pulse_capture(5'd1);
    check_val("b2b_row0", 64'(bus.out_row_idx), 64'(0));
    check_val("b2b_valid", 64'(bus.out_valid), 64'(1));
    check_val("b2b_no_err", 64'(overrun_err), 64'(0));
    repeat (ROWS + 1) step_cycle();

    // Reset mid-drain
    rand_matrix();
    pulse_capture(5'd0);
    step_cycle();
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    check_val("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check_val("mid_rst_cap_ready", 64'(capture_ready), 64'(1));
    rand_matrix();
    pulse_capture(5'd4);
    check_val("mid_rst_row0", 64'(bus.out_row_idx), 64'(0));
    repeat (ROWS + 1) step_cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rand_matrix();
      cfg_shift     = 5'($urandom_range(0, 31));
      result_valid  = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 149) == 0);
      step_cycle();
    end
    reset         = 1'b0;
    result_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (ROWS + 1) step_cycle();

    // Clip flood: drive the counter into saturation and confirm it holds
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        result_matrix[r][c] = 32'h7FFF_FFFF;
    cfg_shift    = 5'd0;
    result_valid = 1'b1;
    repeat (16500) step_cycle();
    result_valid = 1'b0;
    repeat (ROWS + 1) step_cycle();
    check_val("sat_hold_max", 64'(sat_count), 64'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Receiver for the systolic array's result interface.
- Captures the full ROWS x COLS accumulator matrix on a single-cycle result_valid pulse into a local buffer.
- Streams the matrix out one row per beat over a valid/ready handshake, requantizing each ACC_W accumulator to OUT_W with round-half-up and saturation.
- Sits between the array top and the writeback/next-layer activation path.

Parameters:
- ROWS, 4, number of result rows (number of beats per matrix)
- COLS, 4, number of result columns (elements per beat)
- ACC_W, 32, accumulator width of the incoming results
- OUT_W, 8, width of each requantized output element
- SAT_CNT_W, 16, width of the saturation event counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- result_matrix  in  [ROWS][COLS] x ACC_W signed  accumulator results from the array
- result_valid  in  1  single-cycle pulse; result_matrix is valid this cycle
- cfg_shift  in  5  arithmetic right-shift amount, sampled at capture
- capture_ready  out  1  drain can accept a result_valid this cycle
- out_data  out  [COLS] x OUT_W signed  requantized row
- out_row_idx  out  $clog2(ROWS)  index of the row on out_data
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts the beat
- out_last  out  1  high with the beat for row ROWS-1
- overrun_err  out  1  sticky: a result_valid was dropped
- sat_count  out  SAT_CNT_W  saturating count of clipped elements on accepted beats

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - out_valid=0, out_data=0, out_row_idx=0, out_last=0.
  - overrun_err=0, sat_count=0.
  - capture_ready=1 from the first cycle after reset.
  - Buffer contents are don't-care.
- Reset mid-drain: the current matrix is discarded and out_valid=0 the next cycle. There is no partial completion.
- FSM states: IDLE, DRAIN.
  - IDLE + result_valid: capture all ROWS*COLS words and latch cfg_shift (clamped to ACC_W-1 if larger). Set row_ptr=0 and move to DRAIN.
  - DRAIN: out_valid=1 and out_row_idx=row_ptr. out_data is the requantized buffer[row_ptr], combinational from buffer and latched shift.
  - DRAIN + handshake (out_valid && out_ready), row_ptr < ROWS-1: row_ptr increments.
  - DRAIN + handshake, row_ptr == ROWS-1: return to IDLE, unless a back-to-back capture occurs (below).
- Latency: the first beat appears the cycle after the result_valid capture. With out_ready held high, ROWS beats occur on consecutive cycles.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_row_idx and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
  - out_last = DRAIN && row_ptr == ROWS-1.
  - When out_valid=0, out_data is driven to 0.
- capture_ready = IDLE || (DRAIN && row_ptr == ROWS-1 && out_ready). It is combinational.
- Back-to-back: result_valid in the same cycle as the final handshake is accepted. The buffer is overwritten, row_ptr=0, the state stays DRAIN, and row 0 of the new matrix is presented the next cycle.
- Overrun: result_valid while capture_ready=0 is dropped.
  - Buffer and latched shift are unchanged.
  - overrun_err sets and stays set until reset.
  - The drain in progress completes with the original data.
- Requantization, per element:
  - Sign-extend acc to ACC_W+1 bits.
  - Add bias = (s>0) ? 2^(s-1) : 0.
  - Arithmetic right shift by s.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Saturation counter:
  - On each handshake, sat_count increments by the number of clipped elements in that beat (0..COLS).
  - It saturates at all-ones and does not wrap.
  - Stalled cycles do not count.
- The block never modifies the array's result_matrix. Capture is a plain register load with no extra pipeline stage.

Test Plan:
- Basic drain: ROWS=COLS=4, result[r][c]=4r+c, shift 0, out_ready=1, result_valid at cycle 0 -> beats at cycles 1..4; row0={0,1,2,3}, row3={12,13,14,15}; out_last only at cycle 4; capture_ready=1 at cycle 4; out_valid=0 at cycle 5.
- Rounding: with shift=1, 5->3 and -5->-2; with shift=2, 6->2 and -6->-1 -> sat_count stays 0.
- Saturation: shift=0, 1000->127, -1000->-128, 127->127, 0x7FFFFFFF with shift=31->1 -> sat_count=2 after the beat; preload sat_count to all-ones -> it holds.
- Backpressure: out_ready=0 for 3 cycles while row 1 is presented -> out_data, out_row_idx=1 and out_last=0 stable; 4 total handshakes; sat_count not double-counted.
- Overrun/back-to-back:
  - result_valid while row 2 is presented -> overrun_err=1; rows 2,3 carry the first matrix.
  - After reset, second result_valid coincident with the row-3 handshake -> no error; next cycle row 0 of the second matrix.
- Reset mid-drain: reset asserted during row 1 -> out_valid=0 and capture_ready=1 the following cycle; a new result_valid drains from row 0.
